// File: rtl/lut_logic_engine_pkg.sv
// Shared types and sizing helpers for the programmable LUT logic engine.
package logic_engine_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  // Truth-table depth for n inputs.
  function automatic int depth(input int n_in);
    return 1 << n_in;
  endfunction

  // Select width for n outputs; never narrower than one bit.
  function automatic int sel_w(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

endpackage

// File: rtl/lut_logic_engine_bank.sv
// Table storage: N_OUT truth tables with one write port and a combinational read.
module lut_bank
  import logic_engine_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [sel_w(N_OUT)-1:0]  sel,
  input  logic [depth(N_IN)-1:0]   data,
  input  logic [N_IN-1:0]          idx,
  output logic [N_OUT-1:0]         rd
);

  localparam int SW    = sel_w(N_OUT);
  localparam int DEPTH = depth(N_IN);

  logic [N_OUT-1:0][DEPTH-1:0] tbl_q;

  // A select beyond the last table matches no entry and the write is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_q <= '0;
    end else if (we) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (sel == SW'(j)) tbl_q[j] <= data;
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int j = 0; j < N_OUT; j++) rd[j] = tbl_q[j][idx];
  end

endmodule

// File: rtl/lut_logic_engine.sv
// Programmable N_OUT x N_IN logic-function engine with single evaluation and
// an exhaustive sweep mode; one-cycle registered result latency.
module lut_logic_engine
  import logic_engine_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [sel_w(N_OUT)-1:0]  cfg_sel,
  input  logic [depth(N_IN)-1:0]   cfg_table,
  input  logic                     in_valid,
  input  logic [N_IN-1:0]          in_x,
  input  logic                     sweep_start,
  output logic                     sweep_busy,
  output logic                     sweep_done,
  output logic                     out_valid,
  output logic [N_IN-1:0]          out_x,
  output logic [N_OUT-1:0]         out_y
);

  localparam logic [N_IN-1:0] LAST = '1;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   cnt_q, cnt_d, eval_idx;
  logic              eval_en, last_hit;
  logic [N_OUT-1:0]  rd_y;
  logic              out_valid_q, sweep_done_q;
  logic [N_IN-1:0]   out_x_q;
  logic [N_OUT-1:0]  out_y_q;

  assign last_hit = (state_q == SWEEP) && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sweep_start) state_d = SWEEP;
      SWEEP:   if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // sweep_start wins over in_valid; in SWEEP all requests are dropped.
  always_comb begin
    eval_en   = 1'b0;
    eval_idx  = in_x;
    cnt_d     = cnt_q;
    cfg_ready = 1'b1;
    case (state_q)
      IDLE: begin
        if (sweep_start) begin
          eval_en  = 1'b1;
          eval_idx = '0;
          cnt_d    = N_IN'(1);
        end else if (in_valid) begin
          eval_en  = 1'b1;
        end
      end
      SWEEP: begin
        cfg_ready = 1'b0;
        eval_en   = 1'b1;
        eval_idx  = cnt_q;
        cnt_d     = cnt_q + N_IN'(1);
      end
      default: ;
    endcase
  end

  lut_bank #(.N_IN(N_IN), .N_OUT(N_OUT)) u_bank (
    .clk  (clk),
    .rst  (rst),
    .we   (cfg_valid && cfg_ready),
    .sel  (cfg_sel),
    .data (cfg_table),
    .idx  (eval_idx),
    .rd   (rd_y)
  );

  // Bank write lands at the edge, so a same-cycle evaluation sees the old table.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
    end else begin
      out_valid_q  <= eval_en;
      sweep_done_q <= last_hit;
      if (eval_en) begin
        out_x_q <= eval_idx;
        out_y_q <= rd_y;
      end
    end
  end

  assign sweep_busy = (state_q == SWEEP);
  assign sweep_done = sweep_done_q;
  assign out_valid  = out_valid_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;

endmodule
